// File: rtl/prbs_burst_ctrl_pkg.sv
// Shared types and defaults for the PRBS burst sequencer.
// State encoding is fixed so the downstream capture logic can decode it.
package prbs_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int unsigned PKG_LFSR_W       = 4;
    localparam int unsigned PKG_LEN_W        = 4;
    localparam int unsigned PKG_NB_W         = 3;
    // A zero seed would lock the LFSR, so this replaces it.
    localparam int unsigned DEFAULT_SEED_VAL = 1;

endpackage

// File: rtl/prbs_burst_ctrl_if.sv
// Control/config and LFSR-side signals of the burst sequencer.
// master = top-level control side, slave = the sequencer itself.
interface prbs_burst_ctrl_if
    import prbs_burst_ctrl_pkg::*;
#(
    parameter int LFSR_W = int'(PKG_LFSR_W),
    parameter int LEN_W  = int'(PKG_LEN_W),
    parameter int NB_W   = int'(PKG_NB_W)
);
    logic              start;
    logic              stop;
    logic [LEN_W-1:0]  burst_len;
    logic [LEN_W-1:0]  gap_len;
    logic [NB_W-1:0]   num_bursts;
    logic [LFSR_W-1:0] seed_in;

    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              bit_valid;
    logic              frame_start;
    logic [LEN_W-1:0]  bit_cnt;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        output start, stop, burst_len, gap_len, num_bursts, seed_in,
        input  lfsr_load, lfsr_seed, lfsr_en, bit_valid, frame_start,
               bit_cnt, busy, done, aborted
    );

    modport slave (
        input  start, stop, burst_len, gap_len, num_bursts, seed_in,
        output lfsr_load, lfsr_seed, lfsr_en, bit_valid, frame_start,
               bit_cnt, busy, done, aborted
    );

endinterface

// File: rtl/prbs_burst_ctrl_seq_counter.sv
// Up-counter with synchronous clear (priority over enable) and a
// combinational terminal-compare flag against a programmable value.
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer for the PRBS LFSR: seeds it, then gates its shift enable
// into num_bursts+1 bursts of burst_len+1 bits separated by gap_len idle cycles.
module prbs_burst_ctrl
    import prbs_burst_ctrl_pkg::*;
#(
    parameter int                 LFSR_W       = int'(PKG_LFSR_W),
    parameter int                 LEN_W        = int'(PKG_LEN_W),
    parameter int                 NB_W         = int'(PKG_NB_W),
    parameter logic [LFSR_W-1:0]  DEFAULT_SEED = LFSR_W'(DEFAULT_SEED_VAL)
) (
    input  logic               clk,
    input  logic               clr,
    prbs_burst_ctrl_if.slave   bus
);
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  gap_q, gap_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [LFSR_W-1:0] seed_q, seed_d;

    logic              lfsr_load_q, lfsr_load_d;
    logic [LFSR_W-1:0] lfsr_seed_q, lfsr_seed_d;
    logic              lfsr_en_q, lfsr_en_d;
    logic              frame_start_q, frame_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              bit_clr, bit_en, bit_tc;
    logic              gap_clr, gap_en, gap_tc;
    logic              burst_clr, burst_en, burst_tc;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  gap_cnt;
    logic [NB_W-1:0]   burst_idx;
    logic              unused_cnt;

    logic              abort_req;
    logic              burst_end;

    assign abort_req = bus.stop && (state_q != ST_IDLE);
    assign burst_end = (state_q == ST_RUN) && bit_tc;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        gap_d   = gap_q;
        nb_d    = nb_q;
        seed_d  = seed_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = ST_LOAD;
                    len_d   = bus.burst_len;
                    gap_d   = bus.gap_len;
                    nb_d    = bus.num_bursts;
                    seed_d  = (bus.seed_in == '0) ? DEFAULT_SEED : bus.seed_in;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bit_tc) begin
                    if (burst_tc) begin
                        state_d = ST_IDLE;
                    end else if (gap_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop outranks both end-of-run and the normal state progression.
        if (abort_req) begin
            state_d = ST_IDLE;
        end

        // Outputs are registered, so they are decoded from the next state.
        lfsr_load_d   = (state_d == ST_LOAD);
        lfsr_seed_d   = (state_d == ST_LOAD) ? seed_d : '0;
        lfsr_en_d     = (state_d == ST_RUN);
        frame_start_d = (state_d == ST_RUN) && ((state_q != ST_RUN) || bit_tc);
        busy_d        = (state_d != ST_IDLE);
        done_d        = burst_end && burst_tc && !bus.stop;
        aborted_d     = abort_req;
    end

    // Bit index restarts on every burst boundary and outside RUN.
    assign bit_en    = (state_q == ST_RUN);
    assign bit_clr   = clr || (state_d != ST_RUN) || burst_end;

    // Gap terminal fires on the last of gap_q idle cycles.
    assign gap_en    = (state_q == ST_GAP);
    assign gap_clr   = clr || (state_d != ST_GAP);

    assign burst_en  = burst_end;
    assign burst_clr = clr || (state_d == ST_IDLE) || (state_q == ST_LOAD);

    seq_counter #(.W(LEN_W)) u_bit_cnt (
        .clk    (clk),
        .clr_i  (bit_clr),
        .en_i   (bit_en),
        .term_i (len_q),
        .cnt_o  (bit_cnt),
        .tc_o   (bit_tc)
    );

    seq_counter #(.W(LEN_W)) u_gap_cnt (
        .clk    (clk),
        .clr_i  (gap_clr),
        .en_i   (gap_en),
        .term_i (gap_q - LEN_W'(1)),
        .cnt_o  (gap_cnt),
        .tc_o   (gap_tc)
    );

    seq_counter #(.W(NB_W)) u_burst_cnt (
        .clk    (clk),
        .clr_i  (burst_clr),
        .en_i   (burst_en),
        .term_i (nb_q),
        .cnt_o  (burst_idx),
        .tc_o   (burst_tc)
    );

    assign unused_cnt = ^{gap_cnt, burst_idx};

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            gap_q         <= '0;
            nb_q          <= '0;
            seed_q        <= '0;
            lfsr_load_q   <= 1'b0;
            lfsr_seed_q   <= '0;
            lfsr_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            gap_q         <= gap_d;
            nb_q          <= nb_d;
            seed_q        <= seed_d;
            lfsr_load_q   <= lfsr_load_d;
            lfsr_seed_q   <= lfsr_seed_d;
            lfsr_en_q     <= lfsr_en_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    assign bus.lfsr_load   = lfsr_load_q;
    assign bus.lfsr_seed   = lfsr_seed_q;
    assign bus.lfsr_en     = lfsr_en_q;
    assign bus.bit_valid   = lfsr_en_q;
    assign bus.frame_start = frame_start_q;
    assign bus.bit_cnt     = bit_cnt;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.aborted     = aborted_q;

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer for the PRBS LFSR datapath. It seeds the LFSR, then gates its shift-enable to produce a programmed number of fixed-length bursts separated by idle gaps. It also flags frame starts and completion for downstream capture logic. It sits between the top-level control (buttons/registers) and the LFSR/bit-counter datapath.

Parameters:
- LFSR_W, 4, width of the LFSR seed bus.
- LEN_W, 4, width of burst_len and gap_len. A burst is burst_len+1 bits, so 1..16.
- NB_W, 3, width of num_bursts. num_bursts+1 bursts are run, so 1..8.
- DEFAULT_SEED, 4'b0001, seed used when seed_in is all-zero, because a zero seed locks the LFSR.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- clr, in, 1, synchronous active-high reset.
- start, in, 1, level; sampled only in IDLE.
- stop, in, 1, abort request; honoured in any non-IDLE state.
- burst_len, in, LEN_W, bits per burst minus 1.
- gap_len, in, LEN_W, idle cycles between bursts; 0 means back-to-back.
- num_bursts, in, NB_W, bursts per run minus 1.
- seed_in, in, LFSR_W, LFSR seed.
- lfsr_load, out, 1, one-cycle load strobe to the LFSR.
- lfsr_seed, out, LFSR_W, seed presented with lfsr_load.
- lfsr_en, out, 1, LFSR shift enable.
- bit_valid, out, 1, current LFSR output bit belongs to a burst; equals lfsr_en.
- frame_start, out, 1, high on the first bit of each burst.
- bit_cnt, out, LEN_W, index of the current bit within its burst.
- busy, out, 1, high in LOAD, RUN and GAP.
- done, out, 1, one-cycle pulse on normal completion.
- aborted, out, 1, one-cycle pulse when a run is ended by stop.

Behaviour:
- clr is synchronous and has priority over all other inputs. On clr: state=IDLE and all outputs 0, including lfsr_seed, bit_cnt, done and aborted. Internal counters and latched config are also 0.
- States are IDLE, LOAD, RUN and GAP. All outputs are registered.
- IDLE:
  - start=1 and stop=0 latches burst_len, gap_len, num_bursts and seed, then moves to LOAD.
  - The latched seed is DEFAULT_SEED if seed_in==0.
  - Inputs are ignored outside IDLE; later changes do not affect a run.
- LOAD (exactly 1 cycle):
  - lfsr_load=1 and lfsr_seed=latched seed; lfsr_en=0.
  - Next state is RUN with bit_cnt=0 and burst index=0.
- RUN:
  - lfsr_en=bit_valid=1 every cycle.
  - frame_start=1 only when bit_cnt==0.
  - bit_cnt increments by 1 per cycle.
- End of burst (bit_cnt==len_q):
  - If burst index==nb_q: next state IDLE, with done=1 for one cycle in that first IDLE cycle.
  - Else if gap_q==0: stay in RUN, bit_cnt wraps to 0, burst index increments, frame_start=1.
  - Else: go to GAP, gap counter=0.
- GAP:
  - lfsr_en=0 and bit_cnt holds 0.
  - After exactly gap_q cycles, enter RUN with burst index incremented.
  - The LFSR is not reloaded between bursts; the sequence continues.
- stop:
  - In LOAD, RUN or GAP, stop=1 forces IDLE next cycle. aborted pulses 1 cycle and done stays 0.
  - stop beats end-of-run in the same cycle: aborted=1, done=0.
  - stop beats start in IDLE, so no run starts.
- Back-to-back runs: start held high re-launches on the cycle after done (IDLE→LOAD). Minimum IDLE dwell is 1 cycle.
- Latency:
  - start→lfsr_load is 1 cycle; start→first lfsr_en is 2 cycles.
  - Total busy cycles = 1 + (nb+1)(len+1) + nb·gap.
- Widths: counters wrap modulo 2^LEN_W, but the terminal compare fires before any wrap. The burst index is NB_W bits.

Decomposition:
- Shared header prbs_ctrl_defs.vh holds:
  - State encodings: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, GAP=2'd3.
  - DEFAULT_SEED.
- One sub-module: seq_counter, a parameterised-width up-counter with synchronous clr, en and terminal-compare output.
  - Instanced three times: bit counter, gap counter, burst counter.
- The FSM and output registers stay in prbs_burst_ctrl.

Test Plan:
- Reset/idle: assert clr mid-RUN -> next cycle all outputs 0 and state IDLE; start=0 thereafter -> outputs stay 0.
- Single burst, back-to-back path:
  - Stimulus: burst_len=3, num_bursts=0, gap_len=0, seed_in=4'b1011, start pulse.
  - lfsr_load=1 with lfsr_seed=1011 at cycle+1.
  - lfsr_en high for 4 cycles with bit_cnt 0,1,2,3 and frame_start only on the first.
  - done pulses on the next cycle; busy is high for 5 cycles.
- Multi-burst with gap:
  - Stimulus: burst_len=1, num_bursts=2, gap_len=2.
  - lfsr_en pattern after load is 11 00 11 00 11 then done.
  - frame_start fires 3 times; busy for 1+6+4=11 cycles.
- Zero seed and max lengths:
  - seed_in=0 -> lfsr_seed=0001.
  - burst_len=15, num_bursts=7, gap_len=0 -> 128 consecutive lfsr_en cycles and 8 frame_start pulses.
- Abort: stop=1 in GAP of the 2nd burst -> IDLE next cycle, aborted=1 for 1 cycle, done=0, lfsr_en=0.
- Priority: stop and start both high in IDLE -> no LOAD. stop on the final RUN bit -> aborted=1, done=0. start held high -> relaunch LOAD exactly 1 cycle after done.
